// File: rtl/round_key_scheduler_if.sv
// Handshake and read-port bundle for the round key scheduler.
// The master side requests a schedule and reads keys back; the slave side
// is the scheduler itself.
interface round_key_scheduler_if #(
  parameter int regSize = 32,
  parameter int vecSize = 4
) ();

  logic                              start;
  logic [vecSize-1:0][regSize-1:0]   cipher_key;
  logic                              busy;
  logic                              done;
  logic                              keys_valid;
  logic [3:0]                        rd_addr;
  logic [vecSize-1:0][regSize-1:0]   rd_key;

  modport master (
    output start, cipher_key, rd_addr,
    input  busy, done, keys_valid, rd_key
  );

  modport slave (
    input  start, cipher_key, rd_addr,
    output busy, done, keys_valid, rd_key
  );

endinterface

// File: rtl/round_key_scheduler.sv
// AES round key scheduler: expands a cipher key into NROUNDS+1 round keys,
// one round per clock, into a register-based key store with a registered
// read port. The key-expansion step (RotWord, SubWord, Rcon, word chaining)
// is a pure combinational function fed from the store.
module round_key_scheduler #(
  parameter int regSize = 32,
  parameter int vecSize = 4,
  parameter int NROUNDS = 10
) (
  input  logic                  clk,
  input  logic                  rst_n,
  round_key_scheduler_if.slave  bus
);

  typedef logic [regSize-1:0]              word_t;
  typedef logic [vecSize-1:0][regSize-1:0] key_t;
  typedef enum logic [1:0] {IDLE, EXPAND, FINISH} state_t;

  localparam logic [3:0] LAST_RC = 4'(NROUNDS);

  // ---------------------------------------------------------------------------
  // GF(2^8) arithmetic and the AES S-box, computed rather than tabulated.
  // ---------------------------------------------------------------------------
  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = xtime(x);
    end
    return p;
  endfunction

  // Multiplicative inverse as a^254 (maps 0 to 0, as the S-box requires).
  function automatic logic [7:0] gf_inv(input logic [7:0] a);
    logic [7:0] r;
    logic [7:0] sq;
    r  = 8'h01;
    sq = a;
    for (int i = 1; i < 8; i++) begin
      sq = gf_mul(sq, sq);
      r  = gf_mul(r, sq);
    end
    return r;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
    return 8'((b << n) | (b >> (8 - n)));
  endfunction

  function automatic logic [7:0] sbox(input logic [7:0] a);
    logic [7:0] b;
    b = gf_inv(a);
    return b ^ rotl8(b, 1) ^ rotl8(b, 2) ^ rotl8(b, 3) ^ rotl8(b, 4) ^ 8'h63;
  endfunction

  function automatic word_t sub_word(input word_t w);
    word_t s;
    s = '0;
    for (int b = 0; b < regSize / 8; b++) s[8*b +: 8] = sbox(w[8*b +: 8]);
    return s;
  endfunction

  // Round constant: x^(rc-1) in GF(2^8), giving 01,02,04,...,80,1b,36.
  function automatic logic [7:0] rcon_of(input logic [3:0] rc);
    logic [7:0] r;
    r = 8'h01;
    for (int i = 2; i < 16; i++) begin
      if (i <= int'(rc)) r = xtime(r);
    end
    return r;
  endfunction

  // One round of key expansion: word 0 = w0 of the key, as in FIPS-197.
  function automatic key_t key_expand(input key_t k, input logic [3:0] rc);
    word_t t;
    key_t  n;
    t    = k[vecSize-1];
    t    = {t[regSize-9:0], t[regSize-1 -: 8]};
    t    = sub_word(t);
    t    = t ^ (word_t'(rcon_of(rc)) << (regSize - 8));
    n    = '0;
    n[0] = k[0] ^ t;
    for (int i = 1; i < vecSize; i++) n[i] = n[i-1] ^ k[i];
    return n;
  endfunction

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  state_t     state_q;
  logic [3:0] rc_q;
  logic       busy_q;
  logic       done_q;
  logic       keys_valid_q;
  key_t       store_q [NROUNDS+1];
  key_t       rd_key_q;

  logic [3:0] prev_idx_d;
  key_t       next_key_d;

  // Next round key from the previously stored entry.
  // NOTE: every signal assigned in always_comb gets a default first, so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    prev_idx_d = '0;
    if (rc_q != 4'd0) prev_idx_d = rc_q - 4'd1;
    next_key_d = key_expand(store_q[prev_idx_d], rc_q);
  end

  // Schedule FSM, round counter, status outputs and key-store writes.
  // NOTE: state is updated with non-blocking assignments so every register
  // samples the pre-edge value of every other register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      rc_q         <= '0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      keys_valid_q <= 1'b0;
      // NOTE: the key store is explicitly cleared on reset so a read after
      // reset or an aborted schedule never exposes stale key material; this
      // forces flops rather than a RAM macro.
      for (int i = 0; i <= NROUNDS; i++) store_q[i] <= '0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (bus.start) begin
            store_q[0]   <= bus.cipher_key;
            rc_q         <= 4'd1;
            keys_valid_q <= 1'b0;
            busy_q       <= 1'b1;
            state_q      <= EXPAND;
          end
        end
        EXPAND: begin
          store_q[rc_q] <= next_key_d;
          if (rc_q == LAST_RC) begin
            state_q <= FINISH;
          end else begin
            rc_q <= rc_q + 4'd1;
          end
        end
        FINISH: begin
          done_q       <= 1'b1;
          keys_valid_q <= 1'b1;
          busy_q       <= 1'b0;
          state_q      <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Registered read port; out-of-range indices read as zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_key_q <= '0;
    end else if (bus.rd_addr > LAST_RC) begin
      rd_key_q <= '0;
    end else begin
      rd_key_q <= store_q[bus.rd_addr];
    end
  end

  assign bus.busy       = busy_q;
  assign bus.done       = done_q;
  assign bus.keys_valid = keys_valid_q;
  assign bus.rd_key     = rd_key_q;

endmodule

// File: tb/tb_round_key_scheduler.sv
// Self-checking bench for round_key_scheduler: FIPS-197 and zero-key vectors,
// random keys against a word-stream key-expansion model, busy collisions,
// mid-run reset, read bounds and back-to-back schedules.
module tb_round_key_scheduler;

  localparam int REG = 32;
  localparam int VEC = 4;
  localparam int NR  = 10;

  typedef logic [VEC-1:0][REG-1:0] key_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  always #5 clk = ~clk;

  round_key_scheduler_if #(.regSize(REG), .vecSize(VEC)) bus ();

  round_key_scheduler #(.regSize(REG), .vecSize(VEC), .NROUNDS(NR)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int vectors     = 0;
  int miscompares = 0;

  logic [7:0] sbox_tab [256];
  logic [7:0] rcon_tab [10];
  key_t       exp_keys [NR+1];

  // ---------------------------------------------------------------------------
  // Reference model
  // ---------------------------------------------------------------------------
  function automatic logic [7:0] rot8(input logic [7:0] b, input int n);
    return 8'((b << n) | (b >> (8 - n)));
  endfunction

  // S-box built by walking the multiplicative group with generator 3.
  task automatic build_tables();
    logic [7:0] p, q, x;
    p = 8'h01;
    q = 8'h01;
    do begin
      p = p ^ 8'(p << 1) ^ (p[7] ? 8'h1b : 8'h00);
      q = q ^ 8'(q << 1);
      q = q ^ 8'(q << 2);
      q = q ^ 8'(q << 4);
      if (q[7]) q = q ^ 8'h09;
      x = q ^ rot8(q, 1) ^ rot8(q, 2) ^ rot8(q, 3) ^ rot8(q, 4);
      sbox_tab[p] = x ^ 8'h63;
    end while (p != 8'h01);
    sbox_tab[0] = 8'h63;
    rcon_tab = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h1b, 8'h36};
  endtask

  // FIPS-197 word stream w[0..43], grouped four words per round key.
  task automatic compute_model(input key_t k);
    logic [31:0] w [44];
    logic [31:0] t;
    for (int i = 0; i < 4; i++) w[i] = k[i];
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t = {t[23:0], t[31:24]};
        t = {sbox_tab[t[31:24]], sbox_tab[t[23:16]], sbox_tab[t[15:8]], sbox_tab[t[7:0]]};
        t = t ^ {rcon_tab[i/4 - 1], 24'h0};
      end
      w[i] = w[i-4] ^ t;
    end
    for (int r = 0; r <= NR; r++) exp_keys[r] = {w[4*r+3], w[4*r+2], w[4*r+1], w[4*r]};
  endtask

  // ---------------------------------------------------------------------------
  // Stimulus helpers (called at a falling edge, return at a falling edge)
  // ---------------------------------------------------------------------------
  task automatic read_entry(input logic [3:0] addr, output key_t k);
    bus.rd_addr = addr;
    @(negedge clk);
    k = bus.rd_key;
  endtask

  task automatic start_pulse(input key_t k);
    bus.cipher_key = k;
    bus.start      = 1'b1;
    @(negedge clk);
    bus.start      = 1'b0;
  endtask

  task automatic wait_done(output int cyc);
    cyc = -1;
    for (int n = 1; n <= 30; n++) begin
      @(negedge clk);
      if (bus.done === 1'b1) begin
        cyc = n;
        break;
      end
    end
  endtask

  function automatic key_t rand_key();
    key_t k;
    for (int i = 0; i < VEC; i++) k[i] = $urandom;
    return k;
  endfunction

  // ---------------------------------------------------------------------------
  // Tests
  // ---------------------------------------------------------------------------
  task automatic test_reset();
    key_t got;
    rst_n          = 1'b0;
    bus.start      = 1'b0;
    bus.cipher_key = '0;
    bus.rd_addr    = '0;
    @(negedge clk);
    vectors++;
    if ({bus.busy, bus.done, bus.keys_valid} !== 3'b000) begin
      miscompares++;
      $display("FAIL reset_status: got busy/done/kv=%b required 000", {bus.busy, bus.done, bus.keys_valid});
    end
    vectors++;
    if (bus.rd_key !== '0) begin
      miscompares++;
      $display("FAIL reset_rd_key: got %h required 0", bus.rd_key);
    end
    rst_n = 1'b1;
    read_entry(4'd10, got);
    vectors++;
    if (got !== '0) begin
      miscompares++;
      $display("FAIL reset_entry10: got %h required 0", got);
    end
  endtask

  task automatic test_zero_key();
    int   cyc;
    key_t got;
    start_pulse('0);
    wait_done(cyc);
    vectors++;
    if (cyc != NR + 1) begin
      miscompares++;
      $display("FAIL zero_latency: got %0d required %0d", cyc, NR + 1);
    end
    vectors++;
    if ({bus.busy, bus.keys_valid} !== 2'b01) begin
      miscompares++;
      $display("FAIL zero_status: got busy/kv=%b required 01", {bus.busy, bus.keys_valid});
    end
    @(negedge clk);
    vectors++;
    if (bus.done !== 1'b0) begin
      miscompares++;
      $display("FAIL done_pulse_width: got done=%b required 0", bus.done);
    end
    read_entry(4'd1, got);
    vectors++;
    if (got !== {4{32'h62636363}}) begin
      miscompares++;
      $display("FAIL zero_entry1: got %h required %h", got, {4{32'h62636363}});
    end
  endtask

  task automatic test_fips();
    key_t k, got;
    int   cyc;
    k = {32'h09cf4f3c, 32'habf71588, 32'h28aed2a6, 32'h2b7e1516};
    start_pulse(k);
    bus.cipher_key = rand_key();  // must not disturb the running schedule
    wait_done(cyc);
    vectors++;
    if (cyc != NR + 1) begin
      miscompares++;
      $display("FAIL fips_latency: got %0d required %0d", cyc, NR + 1);
    end
    read_entry(4'd0, got);
    vectors++;
    if (got !== k) begin
      miscompares++;
      $display("FAIL fips_entry0: got %h required %h", got, k);
    end
    read_entry(4'd1, got);
    vectors++;
    if (got !== {32'h2a6c7605, 32'h23a33939, 32'h88542cb1, 32'ha0fafe17}) begin
      miscompares++;
      $display("FAIL fips_entry1: got %h required %h", got,
               {32'h2a6c7605, 32'h23a33939, 32'h88542cb1, 32'ha0fafe17});
    end
  endtask

  task automatic test_read_bounds();
    key_t got;
    logic [3:0] bad [2];
    bad = '{4'd11, 4'd15};
    for (int i = 0; i < 2; i++) begin
      read_entry(bad[i], got);
      vectors++;
      if (got !== '0) begin
        miscompares++;
        $display("FAIL read_oob_%0d: got %h required 0", bad[i], got);
      end
    end
    read_entry(4'd10, got);
    vectors++;
    if (got !== {32'hb6630ca6, 32'he13f0cc8, 32'hc9ee2589, 32'hd014f9a8}) begin
      miscompares++;
      $display("FAIL fips_entry10: got %h required %h", got,
               {32'hb6630ca6, 32'he13f0cc8, 32'hc9ee2589, 32'hd014f9a8});
    end
  endtask

  task automatic test_random_keys();
    key_t k, got;
    int   cyc;
    for (int t = 0; t < 4; t++) begin
      k = rand_key();
      compute_model(k);
      start_pulse(k);
      bus.cipher_key = rand_key();
      vectors++;
      if ({bus.busy, bus.keys_valid} !== 2'b10) begin
        miscompares++;
        $display("FAIL rand%0d_running: got busy/kv=%b required 10", t, {bus.busy, bus.keys_valid});
      end
      wait_done(cyc);
      vectors++;
      if (cyc != NR + 1) begin
        miscompares++;
        $display("FAIL rand%0d_latency: got %0d required %0d", t, cyc, NR + 1);
      end
      for (int r = 0; r <= NR; r++) begin
        read_entry(4'(r), got);
        vectors++;
        if (got !== exp_keys[r]) begin
          miscompares++;
          $display("FAIL rand%0d_entry%0d: got %h required %h", t, r, got, exp_keys[r]);
        end
      end
    end
  endtask

  task automatic test_busy_collision();
    key_t ka, kb, got;
    int   done_cnt, done_cyc;
    ka = rand_key();
    kb = rand_key();
    compute_model(ka);
    start_pulse(ka);                       // now after edge 0
    repeat (3) @(negedge clk);             // after edge 3
    bus.cipher_key = kb;
    bus.start      = 1'b1;
    @(negedge clk);                        // edge 4 saw the second start
    bus.start      = 1'b0;
    done_cnt = 0;
    done_cyc = -1;
    for (int n = 5; n <= 30; n++) begin
      @(negedge clk);
      if (bus.done === 1'b1) begin
        done_cnt++;
        done_cyc = n;
      end
    end
    vectors++;
    if (done_cnt != 1 || done_cyc != NR + 1) begin
      miscompares++;
      $display("FAIL collision_done: got %0d pulses last at %0d required 1 at %0d", done_cnt, done_cyc, NR + 1);
    end
    for (int r = 0; r <= NR; r += 5) begin
      read_entry(4'(r), got);
      vectors++;
      if (got !== exp_keys[r]) begin
        miscompares++;
        $display("FAIL collision_entry%0d: got %h required %h", r, got, exp_keys[r]);
      end
    end
  endtask

  task automatic test_mid_reset();
    key_t k, got;
    int   cyc;
    logic saw_done;
    bus.rd_addr = 4'd0;
    k = rand_key();
    start_pulse(k);                        // after edge 0
    repeat (5) @(negedge clk);             // cycle 5
    rst_n = 1'b0;
    #1;
    vectors++;
    if ({bus.busy, bus.done, bus.keys_valid} !== 3'b000 || bus.rd_key !== '0) begin
      miscompares++;
      $display("FAIL midreset_outputs: got busy/done/kv=%b rd_key=%h required 000 and 0",
               {bus.busy, bus.done, bus.keys_valid}, bus.rd_key);
    end
    @(negedge clk);
    rst_n = 1'b1;
    saw_done = 1'b0;
    for (int n = 0; n < 15; n++) begin
      @(negedge clk);
      if (bus.done !== 1'b0 || bus.keys_valid !== 1'b0) saw_done = 1'b1;
    end
    vectors++;
    if (saw_done) begin
      miscompares++;
      $display("FAIL midreset_no_done: got done/kv activity after abort required none");
    end
    read_entry(4'd0, got);
    vectors++;
    if (got !== '0) begin
      miscompares++;
      $display("FAIL midreset_store_cleared: got %h required 0", got);
    end
    k = rand_key();
    compute_model(k);
    start_pulse(k);
    wait_done(cyc);
    vectors++;
    if (cyc != NR + 1) begin
      miscompares++;
      $display("FAIL midreset_restart_latency: got %0d required %0d", cyc, NR + 1);
    end
    read_entry(4'd7, got);
    vectors++;
    if (got !== exp_keys[7]) begin
      miscompares++;
      $display("FAIL midreset_restart_entry7: got %h required %h", got, exp_keys[7]);
    end
  endtask

  task automatic test_back_to_back();
    key_t k1, k2, got;
    int   dones [$];
    logic kv_bad;
    k1 = rand_key();
    k2 = rand_key();
    bus.cipher_key = k1;
    bus.start      = 1'b1;
    @(negedge clk);                        // edge 0 accepted
    kv_bad = 1'b0;
    for (int n = 1; n <= 2 * (NR + 2) - 1; n++) begin
      @(negedge clk);
      if (bus.done === 1'b1) dones.push_back(n);
      if (n >= NR + 2 && n <= 2 * (NR + 2) - 2 && bus.keys_valid !== 1'b0) kv_bad = 1'b1;
      if (n == NR + 1) bus.cipher_key = k2;
    end
    bus.start = 1'b0;
    vectors++;
    if (dones.size() != 2 || dones[0] != NR + 1 || dones[1] != 2 * (NR + 2) - 1) begin
      miscompares++;
      $display("FAIL b2b_done_cycles: got %0d pulses first %0d required 2 at %0d and %0d",
               dones.size(), (dones.size() > 0) ? dones[0] : -1, NR + 1, 2 * (NR + 2) - 1);
    end
    vectors++;
    if (kv_bad || bus.keys_valid !== 1'b1) begin
      miscompares++;
      $display("FAIL b2b_keys_valid: got early valid=%b final kv=%b required 0 and 1", kv_bad, bus.keys_valid);
    end
    compute_model(k2);
    read_entry(4'd10, got);
    vectors++;
    if (got !== exp_keys[10]) begin
      miscompares++;
      $display("FAIL b2b_entry10: got %h required %h", got, exp_keys[10]);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Sequence
  // ---------------------------------------------------------------------------
  initial begin
    build_tables();
    test_reset();
    test_zero_key();
    test_fips();
    test_read_bounds();
    test_random_keys();
    test_busy_collision();
    test_mid_reset();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no completion within 200000 ns required completion");
    $fatal(1, "watchdog expired");
  end

endmodule
